frame_collision_detector: RTL and testbench
===========================================

Name: frame_collision_detector

Overview:
- Parametrised successor to the fixed three-pair collision logic in the VGA game path.
- Takes NUM_OBJ per-pixel drawing requests and checks every enabled object pair for overlap.
- Per pair, emits one registered hit pulse per frame, a per-frame summary word with a valid/ack handshake, and an overflow flag.
- Sits between the object drawers and the game-logic blocks (tower/shot/enemy controllers).

Parameters:
- NUM_OBJ, 4, number of drawing-request inputs (2..16).
- NUM_PAIRS, NUM_OBJ*(NUM_OBJ-1)/2, derived localparam; not overridable.
- PAIR_EN, all ones (NUM_PAIRS bits), per-pair enable mask; a disabled pair never raises any output bit.
- CNT_W, 8, width of each pair's pixel counter (optional feature only).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at frame start
- draw_req  in  NUM_OBJ  bit k = object k drawing at the current pixel
- collision_raw  out  NUM_PAIRS  combinational overlap per enabled pair
- hit_pulse  out  NUM_PAIRS  registered one-cycle pulse, first overlap of the frame per pair
- summary  out  NUM_PAIRS  pairs that collided during the last completed frame
- summary_valid  out  1  summary holds unacknowledged data
- summary_ack  in  1  consumer acknowledge
- summary_ovf  out  1  a non-empty summary was overwritten while still valid (sticky)
- hit_count  out  NUM_PAIRS*CNT_W  per-pair pixel counts of the last frame (optional feature)

Behaviour:
- Pair ordering is lexicographic over i<j: index 0 = (0,1), 1 = (0,2), ..., NUM_OBJ-2 = (0,NUM_OBJ-1), then (1,2), and so on. For NUM_OBJ=4 the order is (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- collision_raw[p] = draw_req[i] & draw_req[j] & PAIR_EN[p]. It is purely combinational, with no latency.
- Internal state per pair:
  - seen[p]: set on the first raw collision of the frame.
  - acc[p]: accumulates the pairs that collided during the current frame.
- hit_pulse[p] is high for exactly one cycle, the cycle after the first raw collision of pair p in a frame (1-cycle latency). Later overlaps in the same frame produce no pulse.
- On a startOfFrame cycle:
  - summary <= acc, where acc holds the previous frame's collisions and excludes the current cycle.
  - acc and seen are cleared, then loaded with the current cycle's raw collisions. A collision in the startOfFrame cycle belongs to the new frame and does generate hit_pulse.
- summary_valid is set at startOfFrame only if the new summary is non-zero. It is cleared by summary_ack when no new non-zero summary lands in the same cycle.
- summary_ack and startOfFrame in the same cycle: the new summary wins, summary_valid stays 1, and no overflow is raised.
- summary_ovf is set when startOfFrame loads a non-zero summary while summary_valid=1 and summary_ack=0. Only reset clears it.
- An all-zero frame still updates summary (to 0) but does not touch summary_valid.
- reset, asynchronous and active-high, at any time, including mid-frame: all registers go to zero. After reset:
  - hit_pulse, summary, summary_valid, summary_ovf and hit_count read 0.
  - The first partial frame is treated as a normal frame.
- startOfFrame pulses longer than one cycle are not supported. Each high cycle counts as a frame boundary.

Optional Feature:
- Macro: COLLISION_PIXEL_COUNT_EN.
- Defined:
  - Each enabled pair has a CNT_W-bit counter that increments on every raw-collision cycle and saturates at 2^CNT_W-1 (no wrap).
  - At startOfFrame the counters are copied to hit_count, then reset to the current cycle's raw value (0 or 1).
  - Pair p occupies bits [p*CNT_W +: CNT_W].
- Undefined: no counters are built and hit_count is tied to 0.

Test Plan (all scenarios use NUM_OBJ=4 and CNT_W=8):
- draw_req=4'b0011 held for 5 cycles mid-frame -> collision_raw=6'b000001 for those 5 cycles. hit_pulse[0] is high for exactly one cycle, the cycle after the first overlap. At the next startOfFrame, summary=6'b000001 and summary_valid=1. With the feature on, hit_count[7:0]=5.
- PAIR_EN=6'b111110 with draw_req=4'b0011 -> collision_raw=0, no hit_pulse, summary stays 0, summary_valid stays 0.
- draw_req=4'b1111 in the same cycle as startOfFrame -> summary receives the old frame's acc. All 6 hit_pulse bits fire in the next cycle. The following startOfFrame gives summary=6'b111111.
- Two consecutive non-empty frames with no ack -> summary_ovf=1 after the second startOfFrame. The flag stays 1 after summary_ack and clears only on reset.
- Feature on, draw_req=4'b1100 held for 300 cycles -> hit_count bits [47:40]=255 (saturated). A reset asserted mid-frame sets all outputs to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/frame_collision_detector.sv
// Per-pair overlap detector for NUM_OBJ drawing requests with per-frame hit pulses and a summary handshake.
// Optional per-pair pixel counters are built when COLLISION_PIXEL_COUNT_EN is defined.
module frame_collision_detector #(
    parameter int NUM_OBJ = 4,
    localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2,
    parameter logic [NUM_PAIRS-1:0] PAIR_EN = '1,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic [NUM_OBJ-1:0]         draw_req,
    output logic [NUM_PAIRS-1:0]       collision_raw,
    output logic [NUM_PAIRS-1:0]       hit_pulse,
    output logic [NUM_PAIRS-1:0]       summary,
    output logic                       summary_valid,
    input  logic                       summary_ack,
    output logic                       summary_ovf,
    output logic [NUM_PAIRS*CNT_W-1:0] hit_count
);

    logic [NUM_PAIRS-1:0] seen_q, seen_d;
    logic [NUM_PAIRS-1:0] acc_q, acc_d;
    logic [NUM_PAIRS-1:0] hit_pulse_q, hit_pulse_d;
    logic [NUM_PAIRS-1:0] summary_q, summary_d;
    logic                 summary_valid_q, summary_valid_d;
    logic                 summary_ovf_q, summary_ovf_d;
    logic                 new_summary_nz;

    // Pair (gi,gj), gi<gj, maps to its lexicographic index.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_OBJ - 1; gi++) begin : g_row
            for (gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
                localparam int P = gi * (2 * NUM_OBJ - gi - 1) / 2 + (gj - gi - 1);
                assign collision_raw[P] = draw_req[gi] & draw_req[gj] & PAIR_EN[P];
            end
        end
    endgenerate

    assign new_summary_nz = |acc_q;

    always_comb begin
        seen_d          = seen_q | collision_raw;
        acc_d           = acc_q | collision_raw;
        hit_pulse_d     = collision_raw & ~seen_q;
        summary_d       = summary_q;
        summary_valid_d = summary_valid_q;
        summary_ovf_d   = summary_ovf_q;
        if (startOfFrame) begin
            // The boundary cycle already belongs to the new frame.
            seen_d      = collision_raw;
            acc_d       = collision_raw;
            hit_pulse_d = collision_raw;
            summary_d   = acc_q;
        end
        if (startOfFrame && new_summary_nz) begin
            summary_valid_d = 1'b1;
            if (summary_valid_q && !summary_ack) begin
                summary_ovf_d = 1'b1;
            end
        end else if (summary_ack) begin
            summary_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q          <= '0;
            acc_q           <= '0;
            hit_pulse_q     <= '0;
            summary_q       <= '0;
            summary_valid_q <= 1'b0;
            summary_ovf_q   <= 1'b0;
        end else begin
            seen_q          <= seen_d;
            acc_q           <= acc_d;
            hit_pulse_q     <= hit_pulse_d;
            summary_q       <= summary_d;
            summary_valid_q <= summary_valid_d;
            summary_ovf_q   <= summary_ovf_d;
        end
    end

    assign hit_pulse     = hit_pulse_q;
    assign summary       = summary_q;
    assign summary_valid = summary_valid_q;
    assign summary_ovf   = summary_ovf_q;

`ifdef COLLISION_PIXEL_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_PAIRS];
    logic [CNT_W-1:0] cnt_d [NUM_PAIRS];
    logic [CNT_W-1:0] hit_count_q [NUM_PAIRS];
    logic [CNT_W-1:0] hit_count_d [NUM_PAIRS];

    generate
        for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_cnt
            always_comb begin
                cnt_d[gi]       = cnt_q[gi];
                hit_count_d[gi] = hit_count_q[gi];
                if (startOfFrame) begin
                    hit_count_d[gi] = cnt_q[gi];
                    cnt_d[gi]       = collision_raw[gi] ? CNT_W'(1) : '0;
                end else if (collision_raw[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                    cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q[gi]       <= '0;
                    hit_count_q[gi] <= '0;
                end else begin
                    cnt_q[gi]       <= cnt_d[gi];
                    hit_count_q[gi] <= hit_count_d[gi];
                end
            end

            assign hit_count[gi*CNT_W +: CNT_W] = hit_count_q[gi];
        end
    endgenerate
`else
    assign hit_count = {(NUM_PAIRS * CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_frame_collision_detector.sv
// Self-checking bench for frame_collision_detector: vector table, directed frame sequences and a random run
// against a frame-level reference model. Two instances share stimulus: full enable mask and pair 0 masked.
module tb_frame_collision_detector;

    localparam int N  = 4;
    localparam int NP = 6;
    localparam int CW = 8;
    localparam logic [NP-1:0] EN_FULL   = 6'b111111;
    localparam logic [NP-1:0] EN_MASKED = 6'b111110;

    logic clk = 1'b0;
    logic reset;
    logic startOfFrame;
    logic [N-1:0] draw_req;
    logic summary_ack;

    logic [NP-1:0]    raw0, pulse0, sum0, raw1, pulse1, sum1;
    logic             val0, ovf0, val1, ovf1;
    logic [NP*CW-1:0] hc0, hc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_collision_detector #(.NUM_OBJ(N), .PAIR_EN(EN_FULL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .draw_req(draw_req),
        .collision_raw(raw0), .hit_pulse(pulse0), .summary(sum0), .summary_valid(val0),
        .summary_ack(summary_ack), .summary_ovf(ovf0), .hit_count(hc0)
    );

    frame_collision_detector #(.NUM_OBJ(N), .PAIR_EN(EN_MASKED), .CNT_W(CW)) dut_m (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .draw_req(draw_req),
        .collision_raw(raw1), .hit_pulse(pulse1), .summary(sum1), .summary_valid(val1),
        .summary_ack(summary_ack), .summary_ovf(ovf1), .hit_count(hc1)
    );

    // Frame-level reference state, one slot per instance.
    logic [NP-1:0] m_frame [2];
    logic [NP-1:0] m_sum   [2];
    logic [NP-1:0] m_pulse [2];
    logic          m_val   [2];
    logic          m_ovf   [2];
    int            m_cnt   [2][NP];
    int            m_hc    [2][NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] overlap(input logic [N-1:0] req, input logic [NP-1:0] en);
        logic [NP-1:0] r;
        int p;
        r = '0;
        p = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                r[p] = req[i] && req[j] && en[p];
                p++;
            end
        end
        return r;
    endfunction

    function automatic logic [NP*CW-1:0] pack_counts(input int k);
        logic [NP*CW-1:0] v;
        v = '0;
`ifdef COLLISION_PIXEL_COUNT_EN
        for (int p = 0; p < NP; p++) v[p*CW +: CW] = CW'(m_hc[k][p]);
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_frame[k] = '0; m_sum[k] = '0; m_pulse[k] = '0;
            m_val[k] = 1'b0; m_ovf[k] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                m_cnt[k][p] = 0;
                m_hc[k][p]  = 0;
            end
        end
    endtask

    task automatic model_step(input logic sof, input logic [N-1:0] req, input logic ack);
        logic [NP-1:0] r;
        for (int k = 0; k < 2; k++) begin
            r = overlap(req, (k == 0) ? EN_FULL : EN_MASKED);
            if (sof) begin
                m_sum[k] = m_frame[k];
                if (m_frame[k] != 0) begin
                    if (m_val[k] && !ack) m_ovf[k] = 1'b1;
                    m_val[k] = 1'b1;
                end else if (ack) begin
                    m_val[k] = 1'b0;
                end
                m_pulse[k] = r;
                m_frame[k] = r;
                for (int p = 0; p < NP; p++) begin
                    m_hc[k][p]  = m_cnt[k][p];
                    m_cnt[k][p] = r[p] ? 1 : 0;
                end
            end else begin
                if (ack) m_val[k] = 1'b0;
                m_pulse[k] = r & ~m_frame[k];
                m_frame[k] = m_frame[k] | r;
                for (int p = 0; p < NP; p++) begin
                    if (r[p] && m_cnt[k][p] < (1 << CW) - 1) m_cnt[k][p]++;
                end
            end
        end
    endtask

    task automatic compare_regs();
        check("pulse",     64'(pulse0), 64'(m_pulse[0]));
        check("summary",   64'(sum0),   64'(m_sum[0]));
        check("valid",     64'(val0),   64'(m_val[0]));
        check("ovf",       64'(ovf0),   64'(m_ovf[0]));
        check("hit_count", 64'(hc0),    64'(pack_counts(0)));
        check("m_pulse",   64'(pulse1), 64'(m_pulse[1]));
        check("m_summary", 64'(sum1),   64'(m_sum[1]));
        check("m_valid",   64'(val1),   64'(m_val[1]));
        check("m_ovf",     64'(ovf1),   64'(m_ovf[1]));
        check("m_hit_count", 64'(hc1),  64'(pack_counts(1)));
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input logic sof, input logic [N-1:0] req, input logic ack);
        startOfFrame = sof;
        draw_req     = req;
        summary_ack  = ack;
        #1;
        check("raw",   64'(raw0), 64'(overlap(req, EN_FULL)));
        check("m_raw", 64'(raw1), 64'(overlap(req, EN_MASKED)));
        model_step(sof, req, ack);
        @(posedge clk);
        #1;
        compare_regs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"},   64'(pulse0), 64'd0);
        check({tag, "_summary"}, 64'(sum0),   64'd0);
        check({tag, "_valid"},   64'(val0),   64'd0);
        check({tag, "_ovf"},     64'(ovf0),   64'd0);
        check({tag, "_hc"},      64'(hc0),    64'd0);
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [NP-1:0] exp_raw;
        logic [NP-1:0] exp_raw_m;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{4'b0011, 6'b000001, 6'b000000};
        vecs[1] = '{4'b0101, 6'b000010, 6'b000010};
        vecs[2] = '{4'b1001, 6'b000100, 6'b000100};
        vecs[3] = '{4'b0110, 6'b001000, 6'b001000};
        vecs[4] = '{4'b1010, 6'b010000, 6'b010000};
        vecs[5] = '{4'b1100, 6'b100000, 6'b100000};
        vecs[6] = '{4'b0111, 6'b001011, 6'b001010};
        vecs[7] = '{4'b1111, 6'b111111, 6'b111110};
        vecs[8] = '{4'b0001, 6'b000000, 6'b000000};
        vecs[9] = '{4'b1110, 6'b111000, 6'b111000};

        reset = 1'b1; startOfFrame = 1'b0; draw_req = '0; summary_ack = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Single pair held for five pixels.
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        check("s1_first_pulse", 64'(pulse0), 64'd1);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 4'b0011, 1'b0);
            check("s1_no_repeat_pulse", 64'(pulse0), 64'd0);
        end
        cycle(1'b1, 4'b0000, 1'b0);
        check("s1_summary", 64'(sum0), 64'd1);
        check("s1_valid",   64'(val0), 64'd1);
        check("s1_masked_valid", 64'(val1), 64'd0);
`ifdef COLLISION_PIXEL_COUNT_EN
        check("s1_count", 64'(hc0[7:0]), 64'd5);
`endif
        $display("seq single_pair done: errors=%0d", errors);

        // Collision in the frame-start cycle belongs to the new frame.
        cycle(1'b0, 4'b0101, 1'b1);
        cycle(1'b1, 4'b1111, 1'b0);
        check("s3_summary_old", 64'(sum0),   64'b000010);
        check("s3_all_pulses",  64'(pulse0), 64'b111111);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0);
        check("s3_summary_new", 64'(sum0), 64'b111111);
        check("s3_no_ovf",      64'(ovf0), 64'd0);
        $display("seq sof_collision done: errors=%0d", errors);

        // Unacknowledged second non-empty frame overflows; ack leaves the flag set.
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);
        check("s4_ovf_set", 64'(ovf0), 64'd1);
        cycle(1'b0, 4'b0000, 1'b1);
        check("s4_valid_acked", 64'(val0), 64'd0);
        check("s4_ovf_sticky",  64'(ovf0), 64'd1);
        $display("seq overflow done: errors=%0d", errors);

        // Counter saturation on pair (2,3).
        cycle(1'b1, 4'b0000, 1'b1);
        for (int c = 0; c < 300; c++) cycle(1'b0, 4'b1100, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1);
`ifdef COLLISION_PIXEL_COUNT_EN
        check("s5_saturated", 64'(hc0[47:40]), 64'd255);
`endif
        check("s5_summary", 64'(sum0), 64'b100000);

        // Asynchronous reset mid-frame, observed before the next clock edge.
        cycle(1'b0, 4'b1111, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        compare_regs();
        $display("seq saturate_reset done: errors=%0d", errors);

        // Acknowledge coinciding with a new non-empty summary.
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1001, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1);
        check("s6_valid_kept", 64'(val0), 64'd1);
        check("s6_no_ovf",     64'(ovf0), 64'd0);
        check("s6_summary",    64'(sum0), 64'b000100);
        // Empty frame updates summary but leaves valid alone.
        cycle(1'b1, 4'b0000, 1'b0);
        check("s7_empty_summary", 64'(sum0), 64'd0);
        check("s7_valid_kept",    64'(val0), 64'd1);
        $display("seq ack_collide done: errors=%0d", errors);

        for (int v = 0; v < 10; v++) begin
            cycle(1'b0, vecs[v].req, 1'b0);
            check("vec_raw",   64'(raw0), 64'(vecs[v].exp_raw));
            check("vec_raw_m", 64'(raw1), 64'(vecs[v].exp_raw_m));
            $display("vec %0d req=%b raw=%b raw_m=%b", v, vecs[v].req, raw0, raw1);
        end

        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 15) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
        end
        $display("random run done: errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
